// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port integer register file with pending scoreboard and write bypass
module reg_file_mp #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NRD       = 2,
  parameter int NWR       = 2,
  parameter int ZERO_REG  = 1,
  parameter int WR_BYPASS = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pending,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  output logic                any_pending
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic [NWR-1:0]   wr_ok;
  logic             sb_ok;

  // Qualify writes and scoreboard sets: address 0 is inert when x0 is hardwired.
  always_comb begin
    wr_ok = '0;
    for (int i = 0; i < NWR; i++) begin
      wr_ok[i] = wr_en[i] && !((ZERO_REG != 0) && (wr_addr[i*AW +: AW] == '0));
    end
    sb_ok = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));
  end

  // Next pending vector: writes clear first, then the set is applied so it wins.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NWR; i++) begin
      if (wr_ok[i]) pending_nxt[wr_addr[i*AW +: AW]] = 1'b0;
    end
    if (sb_ok) pending_nxt[sb_addr] = 1'b1;
  end

  // Register storage; ports are applied in ascending order so the highest index wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_ok[i]) regs[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
      end
    end
  end

  // Pending scoreboard and its registered summary bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      any_pending <= 1'b0;
    end else begin
      pending     <= pending_nxt;
      any_pending <= |pending_nxt;
    end
  end

  // Combinational read ports with optional same-cycle forwarding of write data.
  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
      rd_pending[k]           = pending[rd_addr[k*AW +: AW]];
      if (WR_BYPASS != 0) begin
        for (int i = 0; i < NWR; i++) begin
          if (wr_ok[i] && (wr_addr[i*AW +: AW] == rd_addr[k*AW +: AW])) begin
            rd_data[k*XLEN +: XLEN] = wr_data[i*XLEN +: XLEN];
            rd_pending[k]           = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (rd_addr[k*AW +: AW] == '0)) begin
        rd_data[k*XLEN +: XLEN] = '0;
        rd_pending[k]           = 1'b0;
      end
    end
    if (reset) begin
      rd_data    = '0;
      rd_pending = '0;
    end
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file for the RISC-V core. It provides NRD combinational read ports and NWR synchronous write ports, with an optional hardwired-zero register x0 and optional write-to-read bypass. A per-register pending scoreboard lets the issue stage mark destination registers busy until write-back. It replaces the fixed 2-read/1-write register file used between decode and write-back.

## Interface
- XLEN, 32: register width in bits (8..64).
- NREGS, 32: number of registers; power of two, 2..64.
- NRD, 2: number of read ports, 1..4.
- NWR, 2: number of write ports, 1..3.
- ZERO_REG, 1: 1 = register 0 reads as zero and ignores writes and pending sets.
- WR_BYPASS, 1: 1 = same-cycle write data is forwarded to matching read ports.
- AW (local): clog2(NREGS).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all registers and pending bits.
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational; port k uses bits [k*XLEN +: XLEN].
- rd_pending  out  NRD  pending status of each read address, combinational.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- sb_set  in  1  marks register sb_addr pending at the next edge.
- sb_addr  in  AW  scoreboard set address.
- any_pending  out  1  OR of all pending bits, registered.

## Operation
- Storage: NREGS x XLEN flops and an NREGS-bit pending vector.
- Reset (async assert): all registers = 0, pending = 0, any_pending = 0. While reset is high, rd_data = 0, rd_pending = 0, and writes and sb_set are ignored.
- Write: on a rising edge, each port i with wr_en[i]=1 writes wr_data[i] to wr_addr[i].
- Write conflict: when several enabled ports target the same address, the highest port index wins. No error is flagged.
- Pending clear: every enabled write clears that register's pending bit.
- Pending set: sb_set sets pending[sb_addr]. If set and write hit the same address in one cycle, the set wins and the final pending value is 1.
- ZERO_REG=1: writes to address 0 are dropped; sb_set to address 0 is dropped; reads of address 0 return 0 with pending 0, including under bypass.
- Read: rd_data[k] = reg[rd_addr[k]], rd_pending[k] = pending[rd_addr[k]].
- Bypass (WR_BYPASS=1): if any enabled write port targets rd_addr[k] (excluding address 0 when ZERO_REG), then rd_data[k] = that port's wr_data (highest index on conflict) and rd_pending[k] = 0. An sb_set in the same cycle does not affect the bypassed pending value.
- WR_BYPASS=0: reads return the pre-edge contents only.
- any_pending is registered and reflects the pending vector after each edge.
- Widths: all addresses are used in full; out-of-range addresses cannot occur because NREGS is a power of two.

## Timing
- Read latency: 0 cycles (combinational from address, and from wr_* when bypass is on).
- Write latency: data is visible to non-bypassed reads in the cycle after the write edge.
- Pending: set or clear is visible on rd_pending one cycle after the edge (bypass case excepted). any_pending updates at the same edge as the pending vector.
- Reset deassertion is synchronised externally; the first write takes effect at the first rising edge with reset low.
- Reset asserted mid-cycle clears state immediately, without waiting for a clock edge; an in-flight write is lost.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert reset between edges -> rd_data for x5 reads 0 immediately and any_pending = 0.
- Dual write, different addresses: port0 writes x3 = 0x11, port1 writes x4 = 0x22 -> next cycle, reads of x3 and x4 return 0x11 and 0x22.
- Write conflict: port0 writes x7 = 0xAAAA and port1 writes x7 = 0x5555 in one cycle -> x7 = 0x5555; with bypass on, a same-cycle read of x7 returns 0x5555.
- Zero register: write x0 = 0xFFFFFFFF with sb_set on address 0 -> x0 reads 0, rd_pending = 0, any_pending = 0.
- Scoreboard: sb_set x9 -> rd_pending = 1 and any_pending = 1. A later write to x9 -> pending 0. Set and write to x9 in the same cycle -> pending stays 1 and the data is updated.
- Bypass off (WR_BYPASS=0): write x2 = 0x1234 while reading x2 -> old value in that cycle, 0x1234 in the next cycle.
